circle_plotter: RTL and testbench
=================================

# circle_plotter

Consumer of the ramped note radii: watches the two radius inputs and renders each as a midpoint-algorithm circle into the 160x120 VGA adapter pixel-write port, one pixel per cycle. When a radius changes, it erases the previously drawn circle and draws the new one. The radius ramp therefore appears on screen as a smoothly pulsing pair of concentric rings.

## Interface
- CX, 80, circle centre x
- CY, 60, circle centre y
- COL_HIGH, 3'b111, colour of the high-note circle
- COL_LOW, 3'b011, colour of the low-note circle
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- r_high  in  7  target radius of the high-note circle; 0 = no circle
- r_low  in  7  target radius of the low-note circle; 0 = no circle
- x  out  8  pixel x (0..159)
- y  out  7  pixel y (0..119)
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe; x/y/colour valid in the same cycle
- busy  out  1  high whenever FSM is not in IDLE
- done  out  1  one-cycle pulse on the cycle the FSM re-enters IDLE after a pass

## Operation
- State: drawn_high, drawn_low (7 b, radii currently on screen), FSM {IDLE, SETUP, ERASE, DRAW, NEXT}.
- IDLE: if r_high != drawn_high, latch tgt = r_high, sel = HIGH, go to SETUP. Otherwise, if r_low != drawn_low, do the same with sel = LOW. High has priority.
- A pass for sel runs ERASE on the old radius with colour 0, then DRAW on tgt with COL_sel, then sets drawn_sel = tgt.
- ERASE is skipped when:
  - the old radius is 0, or
  - the old radius equals the other circle's drawn radius (so the other ring is not damaged).
- DRAW is skipped if tgt = 0.
- NEXT: if the other circle is also mismatched, start its pass via SETUP. Otherwise go to IDLE and pulse done.
- Inputs are sampled only in IDLE/NEXT. Changes during a pass are picked up on the next comparison.
- Midpoint loop per circle of radius r:
  - Init: px=0, py=r, d=1-r (signed 9 b).
  - Per step, emit 8 points over 8 cycles in this order: (CX+px,CY+py), (CX-px,CY+py), (CX+px,CY-py), (CX-px,CY-py), (CX+py,CY+px), (CX-py,CY+px), (CX+py,CY-px), (CX-py,CY-px).
  - After the 8th point: if d<0, d += 2px+3; else d += 2(px-py)+5 and py--. Then px++.
  - Continue while px <= py.
- Coordinates are computed as signed 9 b. Any point with x outside 0..159 or y outside 0..119 holds plot=0 for its cycle; the cycle is still consumed. Duplicate points are emitted, not filtered.

## Timing
- Reset: x=0, y=0, colour=0, plot=0, busy=0, done=0, drawn_high=drawn_low=0, FSM=IDLE.
- Reset mid-pass aborts immediately. Nothing is erased; drawn radii become 0.
- All outputs are registered.
- Detection: mismatch seen at edge N (IDLE) → SETUP at N+1 → first plot-cycle output at N+3.
- Each ERASE/DRAW phase lasts exactly 8 × steps cycles. Phases run back-to-back, with one SETUP cycle between ERASE and DRAW.
- busy rises at N+1 and falls in the cycle done pulses.
- r=3 takes 3 steps = 24 cycles. r=1 takes 1 step = 8 cycles.

## Test plan
- Reset, then r_high=3, r_low=0:
  - exactly 24 plot-phase cycles, colour 3'b111; first point (80,63); no erase.
  - done pulses once; drawn_high=3.
- From the r_high=3 state, set r_high=4:
  - 24 erase cycles (colour 0, first point (80,63)), then the r=4 draw with first point (80,64), colour 3'b111.
- r_high=5 and r_low=3 changed in the same cycle from 0:
  - high pass completes first, then low pass, colour 3'b011, first point (80,63).
  - a single done pulse at the end.
- Clipping, r_high=70:
  - every plot=1 cycle has x<=159 and y<=119.
  - the point (80,130) cycle has plot=0.
- Equal radii: r_high=r_low=7 drawn, then r_low=0:
  - no erase pass and no plot pulses, because the old radius equals the other drawn radius; drawn_low=0.
- Assert reset during a DRAW:
  - next cycle plot=0, busy=0.
  - after release with r_high=3, a full 24-cycle draw with no erase.

Source files
------------

// File: rtl/circle_plotter.sv
// Purpose: renders r_high/r_low as concentric midpoint circles into a 160x120 pixel-write port,
//          erasing the previously drawn ring before drawing a changed one.
// Latency: radius mismatch sampled in IDLE -> first pixel strobe three cycles later; one point per cycle.
// Backpressure: none; the pixel port always accepts, radii are re-sampled only in IDLE/NEXT.
// Ports: clock/reset (sync, active-high); r_high/r_low target radii (0 = no circle);
//        x/y/colour/plot pixel write (all registered); busy = FSM not idle; done = end-of-work pulse.
module circle_plotter #(
  parameter int         CX       = 80,
  parameter int         CY       = 60,
  parameter logic [2:0] COL_HIGH = 3'b111,
  parameter logic [2:0] COL_LOW  = 3'b011
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] r_high,
  input  logic [6:0] r_low,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, SETUP, ERASE, DRAW, NEXT} state_t;

  localparam logic signed [8:0] CXS = 9'(CX);
  localparam logic signed [8:0] CYS = 9'(CY);

  state_t state, state_nx;

  logic [6:0]        drawn_high, drawn_low, tgt;
  logic              sel_low;   // 0 = high-note circle, 1 = low-note circle
  logic              erased;    // erase phase of the current pass already handled
  logic [6:0]        px, py;
  logic signed [8:0] d;
  logic [2:0]        k;         // which of the 8 symmetric points this cycle emits

  // FSM strobes
  logic       latch, latch_low, load, step, commit, set_erased, done_nx;
  logic [6:0] r_load;

  logic [6:0]        old_r, oth_r, px_inc, py_nx, a, b;
  logic signed [8:0] d_nx, pxs, pys, sx, sy;
  logic              hi_mis, lo_mis, phase_end, in_range;

  always_comb begin
    old_r  = sel_low ? drawn_low  : drawn_high;
    oth_r  = sel_low ? drawn_high : drawn_low;
    hi_mis = (r_high != drawn_high);
    lo_mis = (r_low  != drawn_low);

    // midpoint step update applied after the 8th point
    pxs    = signed'({2'b00, px});
    pys    = signed'({2'b00, py});
    px_inc = px + 7'd1;
    if (d < 0) begin
      d_nx  = d + (pxs <<< 1) + 9'sd3;
      py_nx = py;
    end else begin
      d_nx  = d + ((pxs - pys) <<< 1) + 9'sd5;
      py_nx = py - 7'd1;
    end
    phase_end = (k == 3'd7) && (px_inc > py_nx);

    // k[2] swaps the axes, k[0] mirrors x, k[1] mirrors y
    a  = k[2] ? py : px;
    b  = k[2] ? px : py;
    sx = k[0] ? CXS - signed'({2'b00, a}) : CXS + signed'({2'b00, a});
    sy = k[1] ? CYS - signed'({2'b00, b}) : CYS + signed'({2'b00, b});
    in_range = !sx[8] && (sx <= 9'sd159) && !sy[8] && (sy <= 9'sd119);
  end

  always_comb begin
    state_nx   = state;
    latch      = 1'b0;
    latch_low  = 1'b0;
    load       = 1'b0;
    r_load     = tgt;
    step       = 1'b0;
    commit     = 1'b0;
    set_erased = 1'b0;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (hi_mis) begin
          latch    = 1'b1;
          state_nx = SETUP;
        end else if (lo_mis) begin
          latch     = 1'b1;
          latch_low = 1'b1;
          state_nx  = SETUP;
        end
      end
      SETUP: begin
        // skip erasing a ring that coincides with the other circle so it stays intact
        if (!erased && old_r != 7'd0 && old_r != oth_r) begin
          load     = 1'b1;
          r_load   = old_r;
          state_nx = ERASE;
        end else if (tgt != 7'd0) begin
          load     = 1'b1;
          state_nx = DRAW;
        end else begin
          commit   = 1'b1;
          state_nx = NEXT;
        end
      end
      ERASE: begin
        step = 1'b1;
        if (phase_end) begin
          set_erased = 1'b1;
          state_nx   = SETUP;
        end
      end
      DRAW: begin
        step = 1'b1;
        if (phase_end) begin
          commit   = 1'b1;
          state_nx = NEXT;
        end
      end
      NEXT: begin
        if (sel_low ? hi_mis : lo_mis) begin
          latch     = 1'b1;
          latch_low = !sel_low;
          state_nx  = SETUP;
        end else begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      drawn_high <= 7'd0;
      drawn_low  <= 7'd0;
      tgt        <= 7'd0;
      sel_low    <= 1'b0;
      erased     <= 1'b0;
      px         <= 7'd0;
      py         <= 7'd0;
      d          <= 9'sd0;
      k          <= 3'd0;
      x          <= 8'd0;
      y          <= 7'd0;
      colour     <= 3'd0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nx;
      if (latch) begin
        tgt     <= latch_low ? r_low : r_high;
        sel_low <= latch_low;
        erased  <= 1'b0;
      end
      if (set_erased) erased <= 1'b1;
      if (commit) begin
        if (sel_low) drawn_low  <= tgt;
        else         drawn_high <= tgt;
      end
      if (load) begin
        px <= 7'd0;
        py <= r_load;
        d  <= 9'sd1 - signed'({2'b00, r_load});
        k  <= 3'd0;
      end else if (step) begin
        k <= k + 3'd1;
        if (k == 3'd7) begin
          px <= px_inc;
          py <= py_nx;
          d  <= d_nx;
        end
      end
      busy <= (state_nx != IDLE);
      done <= done_nx;
      plot <= 1'b0;
      if (state == ERASE || state == DRAW) begin
        x      <= sx[7:0];
        y      <= sy[6:0];
        colour <= (state == DRAW) ? (sel_low ? COL_LOW : COL_HIGH) : 3'b000;
        plot   <= in_range;
      end
    end
  end

endmodule

// File: tb/tb_circle_plotter.sv
module tb_circle_plotter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] r_high = 7'd0;
  logic [6:0] r_low  = 7'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int m_drawn[2];   // [0] high, [1] low: radii the model believes are on screen

  typedef struct {
    bit plot;
    int x;
    int y;
    int col;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t got_q[$];

  circle_plotter dut (
    .clock(clock), .reset(reset), .r_high(r_high), .r_low(r_low),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic void push_blank();
    cyc_t c;
    c.plot = 0; c.x = 0; c.y = 0; c.col = 0;
    exp_q.push_back(c);
  endfunction

  function automatic void push_circle(int r, int col);
    int px = 0;
    int py = r;
    int dd = 1 - r;
    int ptx[8];
    int pty[8];
    cyc_t c;
    do begin
      ptx = '{80+px, 80-px, 80+px, 80-px, 80+py, 80-py, 80+py, 80-py};
      pty = '{60+py, 60+py, 60-py, 60-py, 60+px, 60+px, 60-px, 60-px};
      for (int i = 0; i < 8; i++) begin
        c.x = ptx[i];
        c.y = pty[i];
        c.col = col;
        c.plot = (ptx[i] >= 0 && ptx[i] <= 159 && pty[i] >= 0 && pty[i] <= 119);
        exp_q.push_back(c);
      end
      if (dd < 0) dd += 2*px + 3;
      else begin
        dd += 2*(px - py) + 5;
        py--;
      end
      px++;
    end while (px <= py);
  endfunction

  function automatic void model_pass(int s, int tgt);
    int old = m_drawn[s];
    int oth = m_drawn[1-s];
    push_blank();
    push_blank();
    if (old != 0 && old != oth) begin
      push_circle(old, 0);
      push_blank();
    end
    if (tgt != 0) push_circle(tgt, (s == 0) ? 7 : 3);
    m_drawn[s] = tgt;
  endfunction

  function automatic void model_update(int rh, int rl);
    exp_q.delete();
    if (rh != m_drawn[0]) begin
      model_pass(0, rh);
      if (rl != m_drawn[1]) model_pass(1, rl);
    end else if (rl != m_drawn[1]) begin
      model_pass(1, rl);
      if (rh != m_drawn[0]) model_pass(0, rh);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset;
    reset = 1'b1;
    r_high = 7'd0;
    r_low = 7'd0;
    tick;
    tick;
    reset = 1'b0;
    m_drawn[0] = 0;
    m_drawn[1] = 0;
  endtask

  task automatic run_change(input int rh, input int rl, input string name);
    int n = 0;
    int done_early = 0;
    int lim;
    cyc_t c;
    r_high = 7'(rh);
    r_low = 7'(rl);
    model_update(rh, rl);
    got_q.delete();
    tick;
    while (busy === 1'b1 && n < 6000) begin
      if (done !== 1'b0) done_early++;
      c.plot = plot; c.x = int'(x); c.y = int'(y); c.col = int'(colour);
      got_q.push_back(c);
      tick;
      n++;
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    vectors++;
    if (done_early != 0) begin
      miscompares++;
      $display("FAIL %s done_during_busy got %0d want 0", name, done_early);
    end
    vectors++;
    if (done !== ((exp_q.size() > 0) ? 1'b1 : 1'b0)) begin
      miscompares++;
      $display("FAIL %s done_at_end got %b want %0d", name, done, exp_q.size() > 0);
    end
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      vectors++;
      if (got_q[i].plot != exp_q[i].plot ||
          (exp_q[i].plot && (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y ||
                             got_q[i].col != exp_q[i].col))) begin
        miscompares++;
        $display("FAIL %s cycle %0d got plot=%0d (%0d,%0d) c=%0d want plot=%0d (%0d,%0d) c=%0d",
                 name, i, got_q[i].plot, got_q[i].x, got_q[i].y, got_q[i].col,
                 exp_q[i].plot, exp_q[i].x, exp_q[i].y, exp_q[i].col);
      end
    end
    tick;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done got done=%b busy=%b want 0 0", name, done, busy);
    end
    vectors++;
    if (dut.drawn_high !== 7'(m_drawn[0]) || dut.drawn_low !== 7'(m_drawn[1])) begin
      miscompares++;
      $display("FAIL %s drawn got %0d/%0d want %0d/%0d", name, dut.drawn_high, dut.drawn_low,
               m_drawn[0], m_drawn[1]);
    end
  endtask

  function automatic int count_plots();
    int n = 0;
    foreach (got_q[i]) if (got_q[i].plot) n++;
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset;
    vectors++;
    if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_xyc got %0d,%0d,%0d want 0,0,0", x, y, colour);
    end
    vectors++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got plot=%b busy=%b done=%b want 0 0 0", plot, busy, done);
    end
  endtask

  task automatic test_first_draw;
    run_change(3, 0, "first_draw");
    vectors++;
    if (count_plots() != 24) begin
      miscompares++;
      $display("FAIL first_draw plots got %0d want 24", count_plots());
    end
    vectors++;
    if (got_q.size() < 3 || got_q[2].plot != 1 || got_q[2].x != 80 || got_q[2].y != 63 ||
        got_q[2].col != 7) begin
      miscompares++;
      $display("FAIL first_draw first_point got size=%0d want (80,63) c=7", got_q.size());
    end
  endtask

  task automatic test_grow;
    run_change(4, 0, "grow");
    vectors++;
    if (got_q.size() < 28 || got_q[2].x != 80 || got_q[2].y != 63 || got_q[2].col != 0 ||
        got_q[27].x != 80 || got_q[27].y != 64 || got_q[27].col != 7 || got_q[26].plot != 0) begin
      miscompares++;
      $display("FAIL grow erase_then_draw got size=%0d want erase (80,63) c0 then (80,64) c7",
               got_q.size());
    end
  endtask

  task automatic test_both;
    int idx = -1;
    do_reset;
    run_change(5, 3, "both");
    foreach (got_q[i]) if (idx < 0 && got_q[i].plot && got_q[i].col == 3) idx = i;
    vectors++;
    if (idx < 0 || got_q[idx].x != 80 || got_q[idx].y != 63 || got_q[0].plot != 0 ||
        got_q[2].col != 7) begin
      miscompares++;
      $display("FAIL both low_after_high got idx=%0d want low first point (80,63)", idx);
    end
  endtask

  task automatic test_clip;
    int bad = 0;
    do_reset;
    run_change(70, 0, "clip");
    foreach (got_q[i]) if (got_q[i].plot && (got_q[i].x > 159 || got_q[i].y > 119)) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL clip out_of_range_plots got %0d want 0", bad);
    end
    vectors++;
    if (got_q.size() < 3 || got_q[2].plot != 0) begin
      miscompares++;
      $display("FAIL clip point_80_130 got size=%0d plot=1 want plot=0", got_q.size());
    end
  endtask

  task automatic test_equal;
    do_reset;
    run_change(7, 7, "equal_draw");
    run_change(7, 0, "equal_clear");
    vectors++;
    if (count_plots() != 0 || dut.drawn_low !== 7'd0) begin
      miscompares++;
      $display("FAIL equal_clear plots=%0d drawn_low=%0d want 0 0", count_plots(), dut.drawn_low);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    r_high = 7'd40;
    for (int i = 0; i < 12; i++) tick;
    reset = 1'b1;
    r_high = 7'd3;
    r_low = 7'd0;
    tick;
    vectors++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got plot=%b busy=%b want 0 0", plot, busy);
    end
    reset = 1'b0;
    m_drawn[0] = 0;
    m_drawn[1] = 0;
    run_change(3, 0, "after_reset");
    vectors++;
    if (count_plots() != 24) begin
      miscompares++;
      $display("FAIL after_reset plots got %0d want 24", count_plots());
    end
  endtask

  task automatic test_random;
    int rh, rl;
    rh = m_drawn[0];
    rl = m_drawn[1];
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 3) != 0) rh = $urandom_range(0, 40);
      case ($urandom_range(0, 3))
        0: rl = rh;
        1: ;
        default: rl = $urandom_range(0, 40);
      endcase
      run_change(rh, rl, "random");
    end
  endtask

  initial begin
    test_reset;
    test_first_draw;
    test_grow;
    test_both;
    test_clip;
    test_equal;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
